alu_operand_seq: RTL and testbench
==================================

# alu_operand_seq

Upstream operand sequencer for the 16-bit combinational ALU (`aluIn`). It accepts decoded register-register instructions over a valid/ready handshake and reads both operands from an internal 8 x 16-bit register file. It drives the ALU's `x`, `y` and `opcode` inputs from registered values, captures the ALU result `s` and writes it back to the destination register. It reports completion, zero/negative flags and illegal opcodes.

## Interface
Parameters:
- `NREGS`, 8, register-file depth (power of two; index width `$clog2(NREGS)`, 3 at default)
- `W`, 16, data width; must equal the ALU width

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  instruction offered
- `in_ready`  out  1  sequencer can accept; high only in IDLE
- `in_op`  in  3  ALU opcode: 000 AND, 001 OR, 010 ADD, 110 SUB; all others illegal
- `in_rd`, `in_rs`, `in_rt`  in  3 each  destination, source-x and source-y register indices
- `alu_x`, `alu_y`  out  W  operands to ALU, registered
- `alu_op`  out  3  opcode to ALU, registered
- `alu_s`  in  W  ALU result, combinational from `alu_x`/`alu_y`/`alu_op`
- `host_we`  in  1  host register write strobe
- `host_addr`  in  3  host write/read index
- `host_wdata`  in  W  host write data
- `host_rdata`  out  W  combinational read of `regs[host_addr]`
- `done`  out  1  one-cycle pulse at writeback
- `err`  out  1  one-cycle pulse, coincident with `done`, for an illegal opcode
- `flag_z`, `flag_n`  out  1 each  result == 0 and result[W-1]; updated at writeback of a legal op only

## Operation
- FSM states: IDLE, READ, EXEC, WB.
  - IDLE -> READ on `in_valid & in_ready`. The instruction fields are latched at this edge.
  - READ -> EXEC unconditionally. Load `alu_x <= regs[rs]`, `alu_y <= regs[rt]`, `alu_op <= op`.
  - EXEC -> WB unconditionally. Capture `res <= alu_s`.
  - WB -> IDLE unconditionally. If the opcode is legal, write `regs[rd] <= res` and update the flags. Pulse `done`, and pulse `err` if the opcode is illegal.
- Register 0 reads as zero. Writes to register 0 from WB or from the host port are discarded. Flags still reflect `res` when rd == 0.
- Illegal opcode: the instruction still passes through READ and EXEC, but there is no register write, the flags hold their values, and `err` = 1 in WB.
- Host port: the host write takes effect in any state.
  - When a WB write and a host write hit the same register in the same cycle, the WB write wins and the host write is dropped.
  - A host write during READ to a source register is not seen by that instruction; the operands are sampled at the READ edge from the pre-write values.
- Arithmetic is modulo 2^W, and the ALU carry-out is ignored. SUB computes `rs - rt` in two's complement.
- `in_valid` outside IDLE is ignored. No instruction is queued.

## Timing
- Reset values: state IDLE, `in_ready` = 1, `alu_x` = `alu_y` = 0, `alu_op` = 000, `done` = `err` = 0, `flag_z` = 1, `flag_n` = 0, all registers 0.
- Latency is 4 cycles from the accept edge (cycle 0) to the `done` pulse (cycle 3). `regs[rd]` holds the new value from cycle 4.
- Back-to-back throughput is one instruction per 4 cycles. `in_ready` rises in the cycle after WB.
- The ALU has one full cycle (EXEC) to settle. `alu_*` are stable from the READ edge to the next READ edge.
- A reset mid-instruction returns to IDLE immediately. The register file is cleared and no writeback or `done` occurs.
- A dependent following instruction (RAW on rd) reads the updated value, because writeback completes before the next accept.

## Structure
- Shared package `alu_pkg`:
  - opcode constants `OP_AND`=3'b000, `OP_OR`=3'b001, `OP_ADD`=3'b010, `OP_SUB`=3'b110
  - the state enum
  - the function `op_legal()`
- One sub-module: `alu_regfile`, holding the NREGS x W register array with the two-read sampling, r0-zero and WB-over-host write-priority rules. The FSM and the operand/result registers live in the top level.
- `aluIn` is instantiated by the enclosing datapath, not inside this block.

## Test plan
- Reset mid-EXEC (`rst_n` low for 1 cycle):
  - Then: state IDLE, `in_ready` = 1, no `done`, `host_rdata` for every register = 0.
- Host writes r1=0x0005, r2=0x0003; issue ADD r3,r1,r2:
  - `done` at cycle 3, r3 = 0x0008, `flag_z` = 0, `flag_n` = 0, `alu_op` = 010 during EXEC.
- SUB r4,r2,r1 (3-5):
  - r4 = 0xFFFE, `flag_n` = 1.
  - Then SUB r5,r1,r1: r5 = 0x0000, `flag_z` = 1.
- AND/OR with r1=0xF0F0, r2=0x0FF0:
  - AND gives 0x00F0; OR gives 0xFFF0.
  - Back-to-back issue: second accept exactly 4 cycles after the first; the RAW dependent instruction sees the new value.
- Illegal op 3'b111 to r6:
  - `err` = `done` = 1 in the same cycle, r6 unchanged, flags unchanged.
  - ADD targeting r0: r0 still reads 0.
- Same-cycle host write and WB to r3 (host 0x1234, WB 0x0008):
  - r3 = 0x0008.
  - `in_valid` held high during READ/EXEC/WB: no extra accept.

Source files
------------

// File: rtl/alu_pkg.sv
// Purpose: shared opcodes, sequencer state encoding and opcode legality check.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  // Only the four ALU functions are legal; everything else is flagged as err at writeback.
  function automatic logic op_legal(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_operand_seq_if.sv
// Purpose: instruction channel (valid/ready plus decoded opcode and register indices).
// Latency: n/a (wiring only).
// Backpressure: in_ready from the sequencer gates acceptance of in_valid.
interface alu_operand_seq_if #(
  parameter int AW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [AW-1:0] in_rd;
  logic [AW-1:0] in_rs;
  logic [AW-1:0] in_rt;

  modport master (output in_valid, output in_op, output in_rd, output in_rs, output in_rt,
                  input in_ready);
  modport slave  (input in_valid, input in_op, input in_rd, input in_rs, input in_rt,
                  output in_ready);
endinterface

// File: rtl/alu_regfile.sv
// Purpose: NREGS x W register file, two combinational operand reads, r0 hardwired to zero.
// Latency: reads combinational; writes visible the cycle after the write strobe.
// Backpressure: none; writeback beats the host when both hit one register in a cycle.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int W     = 16,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  output logic [W-1:0]  rs_dat,
  output logic [W-1:0]  rt_dat,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_addr,
  input  logic [W-1:0]  wb_dat,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [W-1:0]  host_wdata,
  output logic [W-1:0]  host_rdata
);

  logic [W-1:0] regs_q [NREGS];
  logic [W-1:0] regs_d [NREGS];

  // Next-state of the array: host write first, writeback applied last so it wins a collision.
  always_comb begin
    regs_d = regs_q;
    if (host_we && (host_addr != '0)) begin
      regs_d[host_addr] = host_wdata;
    end
    if (wb_we && (wb_addr != '0)) begin
      regs_d[wb_addr] = wb_dat;
    end
  end

  // Register storage; reset clears every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Reads return pre-write contents, so a same-edge host write is not seen by the sampler.
  assign rs_dat     = (rs_addr   == '0) ? '0 : regs_q[rs_addr];
  assign rt_dat     = (rt_addr   == '0) ? '0 : regs_q[rt_addr];
  assign host_rdata = (host_addr == '0) ? '0 : regs_q[host_addr];

endmodule

// File: rtl/alu_operand_seq.sv
// Purpose: sequences one reg-reg instruction through an external combinational ALU and writes back.
// Latency: accept in cycle 0, done/err pulse in cycle 3, destination updated from cycle 4.
// Backpressure: in_ready high only in IDLE; nothing is queued, one instruction per 4 cycles.
module alu_operand_seq
  import alu_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int W     = 16,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_operand_seq_if.slave    in_if,
  output logic [W-1:0]        alu_x,
  output logic [W-1:0]        alu_y,
  output logic [2:0]          alu_op,
  input  logic [W-1:0]        alu_s,
  input  logic                host_we,
  input  logic [AW-1:0]       host_addr,
  input  logic [W-1:0]        host_wdata,
  output logic [W-1:0]        host_rdata,
  output logic                done,
  output logic                err,
  output logic                flag_z,
  output logic                flag_n
);

  state_e        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] rs_q, rs_d;
  logic [AW-1:0] rt_q, rt_d;
  logic [W-1:0]  alu_x_q, alu_x_d;
  logic [W-1:0]  alu_y_q, alu_y_d;
  logic [2:0]    alu_op_q, alu_op_d;
  logic [W-1:0]  res_q, res_d;
  logic          flag_z_q, flag_z_d;
  logic          flag_n_q, flag_n_d;

  logic [W-1:0]  rs_dat;
  logic [W-1:0]  rt_dat;
  logic          in_wb;
  logic          legal;
  logic          wb_we;

  assign in_wb = (state_q == ST_WB);
  assign legal = op_legal(op_q);
  assign wb_we = in_wb && legal;

  alu_regfile #(
    .NREGS (NREGS),
    .W     (W)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .rs_addr    (rs_q),
    .rt_addr    (rt_q),
    .rs_dat     (rs_dat),
    .rt_dat     (rt_dat),
    .wb_we      (wb_we),
    .wb_addr    (rd_q),
    .wb_dat     (res_q),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata)
  );

  // FSM and datapath next-state: latch instruction, sample operands, capture result, update flags.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    alu_x_d  = alu_x_q;
    alu_y_d  = alu_y_q;
    alu_op_d = alu_op_q;
    res_d    = res_q;
    flag_z_d = flag_z_q;
    flag_n_d = flag_n_q;
    case (state_q)
      ST_IDLE: begin
        if (in_if.in_valid) begin
          state_d = ST_READ;
          op_d    = in_if.in_op;
          rd_d    = in_if.in_rd;
          rs_d    = in_if.in_rs;
          rt_d    = in_if.in_rt;
        end
      end
      ST_READ: begin
        alu_x_d  = rs_dat;
        alu_y_d  = rt_dat;
        alu_op_d = op_q;
        state_d  = ST_EXEC;
      end
      ST_EXEC: begin
        res_d   = alu_s;
        state_d = ST_WB;
      end
      ST_WB: begin
        // Flags follow the result even when rd is r0; illegal ops leave them untouched.
        if (legal) begin
          flag_z_d = (res_q == '0);
          flag_n_d = res_q[W-1];
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state and operand/result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_AND;
      rd_q     <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      alu_x_q  <= '0;
      alu_y_q  <= '0;
      alu_op_q <= OP_AND;
      res_q    <= '0;
      flag_z_q <= 1'b1;
      flag_n_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      alu_x_q  <= alu_x_d;
      alu_y_q  <= alu_y_d;
      alu_op_q <= alu_op_d;
      res_q    <= res_d;
      flag_z_q <= flag_z_d;
      flag_n_q <= flag_n_d;
    end
  end

  assign in_if.in_ready = (state_q == ST_IDLE);
  assign alu_x          = alu_x_q;
  assign alu_y          = alu_y_q;
  assign alu_op         = alu_op_q;
  assign done           = in_wb;
  assign err            = in_wb && !legal;
  assign flag_z         = flag_z_q;
  assign flag_n         = flag_n_q;

endmodule

// File: tb/tb_alu_operand_seq.sv
// Purpose: directed bench for alu_operand_seq with a behavioural 16-bit ALU attached.
// Latency: checks the 4-cycle accept-to-done cadence and cycle-4 register visibility.
// Backpressure: holds in_valid across a busy instruction to confirm nothing extra is accepted.
module tb_alu_operand_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] alu_x, alu_y, alu_s;
  logic [2:0]  alu_op;
  logic        host_we;
  logic [2:0]  host_addr;
  logic [15:0] host_wdata, host_rdata;
  logic        done, err, flag_z, flag_n;

  int  n_tests = 0;
  int  n_fail  = 0;
  time t_acc   = 0;
  time t_prev  = 0;

  alu_operand_seq_if in_if ();

  alu_operand_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_if      (in_if),
    .alu_x      (alu_x),
    .alu_y      (alu_y),
    .alu_op     (alu_op),
    .alu_s      (alu_s),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .done       (done),
    .err        (err),
    .flag_z     (flag_z),
    .flag_n     (flag_n)
  );

  always #5 clk = ~clk;

  // Reference combinational ALU standing in for aluIn.
  always_comb begin
    case (alu_op)
      OP_AND:  alu_s = alu_x & alu_y;
      OP_OR:   alu_s = alu_x | alu_y;
      OP_ADD:  alu_s = alu_x + alu_y;
      OP_SUB:  alu_s = alu_x - alu_y;
      default: alu_s = 16'h0000;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hwrite(input logic [2:0] a, input logic [15:0] d);
    host_we    = 1'b1;
    host_addr  = a;
    host_wdata = d;
    step();
    host_we    = 1'b0;
  endtask

  task automatic hread(input string tag, input logic [2:0] a, input logic [15:0] exp);
    host_addr = a;
    #1;
    chk(tag, host_rdata, exp);
  endtask

  // Issues one instruction from IDLE and walks it through READ, EXEC, WB into cycle 4.
  task automatic run(input string tag, input logic [2:0] op, input logic [2:0] rd,
                     input logic [2:0] rs, input logic [2:0] rt,
                     input logic [15:0] ex, input logic [15:0] ey, input logic exp_err);
    in_if.in_valid = 1'b1;
    in_if.in_op    = op;
    in_if.in_rd    = rd;
    in_if.in_rs    = rs;
    in_if.in_rt    = rt;
    chk({tag, "_rdy_idle"}, in_if.in_ready, 1);
    @(posedge clk);
    t_acc = $time;
    #1;
    in_if.in_valid = 1'b0;
    chk({tag, "_rdy_read"}, in_if.in_ready, 0);
    chk({tag, "_done_c1"}, done, 0);
    step();
    chk({tag, "_op_exec"}, alu_op, op);
    chk({tag, "_x_exec"}, alu_x, ex);
    chk({tag, "_y_exec"}, alu_y, ey);
    chk({tag, "_done_c2"}, done, 0);
    step();
    chk({tag, "_done_c3"}, done, 1);
    chk({tag, "_err_c3"}, err, exp_err);
    step();
    chk({tag, "_done_c4"}, done, 0);
    chk({tag, "_rdy_c4"}, in_if.in_ready, 1);
  endtask

  initial begin
    rst_n          = 1'b0;
    in_if.in_valid = 1'b0;
    in_if.in_op    = 3'b000;
    in_if.in_rd    = 3'd0;
    in_if.in_rs    = 3'd0;
    in_if.in_rt    = 3'd0;
    host_we        = 1'b0;
    host_addr      = 3'd0;
    host_wdata     = 16'h0000;

    #12;
    chk("rst_ready", in_if.in_ready, 1);
    chk("rst_alu_x", alu_x, 0);
    chk("rst_alu_y", alu_y, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_flag_z", flag_z, 1);
    chk("rst_flag_n", flag_n, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset in the middle of EXEC: back to IDLE, file cleared, no writeback.
    hwrite(3'd1, 16'h0005);
    hwrite(3'd2, 16'h0003);
    in_if.in_valid = 1'b1;
    in_if.in_op    = OP_ADD;
    in_if.in_rd    = 3'd7;
    in_if.in_rs    = 3'd1;
    in_if.in_rt    = 3'd2;
    step();
    in_if.in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", in_if.in_ready, 1);
    chk("mid_rst_done", done, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("mid_rst_done_after", done, 0);
    for (int i = 0; i < 8; i++) begin
      hread($sformatf("mid_rst_r%0d", i), 3'(i), 16'h0000);
    end
    step();
    chk("mid_rst_no_wb", done, 0);
    chk("mid_rst_flag_z", flag_z, 1);

    // ADD r3 = 5 + 3.
    hwrite(3'd1, 16'h0005);
    hwrite(3'd2, 16'h0003);
    run("add", OP_ADD, 3'd3, 3'd1, 3'd2, 16'h0005, 16'h0003, 1'b0);
    hread("add_r3", 3'd3, 16'h0008);
    chk("add_z", flag_z, 0);
    chk("add_n", flag_n, 0);

    // SUB r4 = 3 - 5, then SUB r5 = 5 - 5.
    run("sub_neg", OP_SUB, 3'd4, 3'd2, 3'd1, 16'h0003, 16'h0005, 1'b0);
    hread("sub_neg_r4", 3'd4, 16'hFFFE);
    chk("sub_neg_n", flag_n, 1);
    chk("sub_neg_z", flag_z, 0);
    run("sub_zero", OP_SUB, 3'd5, 3'd1, 3'd1, 16'h0005, 16'h0005, 1'b0);
    hread("sub_zero_r5", 3'd5, 16'h0000);
    chk("sub_zero_z", flag_z, 1);
    chk("sub_zero_n", flag_n, 0);

    // AND, OR, dependent ADD issued back to back.
    hwrite(3'd1, 16'hF0F0);
    hwrite(3'd2, 16'h0FF0);
    run("and", OP_AND, 3'd4, 3'd1, 3'd2, 16'hF0F0, 16'h0FF0, 1'b0);
    hread("and_r4", 3'd4, 16'h00F0);
    t_prev = t_acc;
    run("or", OP_OR, 3'd5, 3'd1, 3'd2, 16'hF0F0, 16'h0FF0, 1'b0);
    chk("b2b_spacing_1", 32'(t_acc - t_prev), 40);
    hread("or_r5", 3'd5, 16'hFFF0);
    chk("or_n", flag_n, 1);
    t_prev = t_acc;
    run("raw", OP_ADD, 3'd6, 3'd4, 3'd5, 16'h00F0, 16'hFFF0, 1'b0);
    chk("b2b_spacing_2", 32'(t_acc - t_prev), 40);
    hread("raw_r6", 3'd6, 16'h00E0);
    chk("raw_z", flag_z, 0);
    chk("raw_n", flag_n, 0);

    // Illegal opcode: err with done, no write, flags frozen (n=1 from the OR).
    run("or2", OP_OR, 3'd7, 3'd1, 3'd2, 16'hF0F0, 16'h0FF0, 1'b0);
    run("illegal", 3'b111, 3'd6, 3'd1, 3'd2, 16'hF0F0, 16'h0FF0, 1'b1);
    hread("illegal_r6", 3'd6, 16'h00E0);
    chk("illegal_z", flag_z, 0);
    chk("illegal_n", flag_n, 1);

    // ADD into r0: discarded, flags still follow the result 0x1FE0.
    run("add_r0", OP_ADD, 3'd0, 3'd2, 3'd2, 16'h0FF0, 16'h0FF0, 1'b0);
    hread("add_r0_r0", 3'd0, 16'h0000);
    chk("add_r0_n", flag_n, 0);
    chk("add_r0_z", flag_z, 0);
    hwrite(3'd0, 16'hBEEF);
    hread("host_r0", 3'd0, 16'h0000);

    // Host write to a source during READ, host/WB collision on r3, in_valid held throughout.
    hwrite(3'd1, 16'h0005);
    hwrite(3'd2, 16'h0003);
    hwrite(3'd3, 16'h0000);
    in_if.in_valid = 1'b1;
    in_if.in_op    = OP_ADD;
    in_if.in_rd    = 3'd3;
    in_if.in_rs    = 3'd1;
    in_if.in_rt    = 3'd2;
    step();
    host_we    = 1'b1;
    host_addr  = 3'd1;
    host_wdata = 16'h0100;
    chk("hold_rdy_read", in_if.in_ready, 0);
    step();
    host_we = 1'b0;
    chk("hold_x_pre_write", alu_x, 16'h0005);
    chk("hold_rdy_exec", in_if.in_ready, 0);
    chk("hold_done_exec", done, 0);
    host_we    = 1'b1;
    host_addr  = 3'd3;
    host_wdata = 16'h1234;
    step();
    chk("hold_done_wb", done, 1);
    chk("hold_rdy_wb", in_if.in_ready, 0);
    step();
    host_we        = 1'b0;
    in_if.in_valid = 1'b0;
    chk("hold_done_c4", done, 0);
    hread("collide_r3", 3'd3, 16'h0008);
    hread("read_host_r1", 3'd1, 16'h0100);
    step();
    chk("hold_no_extra_accept", in_if.in_ready, 1);
    chk("hold_no_extra_done", done, 0);
    chk("collide_z", flag_z, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
